method_call_arbiter: RTL and testbench
======================================

Name: method_call_arbiter

Overview:
- Shares one generated method unit among N_CLIENTS requesters. The method unit uses the req/busy/return call handshake.
- Each client sees its own req/busy/done/return call interface.
- Grants are round-robin. Exactly one method call is in flight at a time.
- Sits between test or control sequencers and a single method instance, e.g. a test method with a 1-bit return.

Parameters:
- N_CLIENTS, 4, number of requesters (2..16)
- RET_WIDTH, 1, width of the method return value
- ID_WIDTH, 2, width of grant_id; must be at least clog2(N_CLIENTS)
- TIMEOUT, 100000, cycles allowed per call before abort (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset: reset==0 at a clk edge resets the block
- cli_req  in  N_CLIENTS  level request per client
- cli_busy  out  N_CLIENTS  client's call is being served
- cli_done  out  N_CLIENTS  1-cycle completion pulse per client
- cli_return  out  RET_WIDTH  result of the completed call; valid while any cli_done bit is 1
- cli_error  out  1  call aborted by timeout; valid with cli_done
- m_req  out  1  request to the method unit
- m_busy  in  1  method unit busy
- m_return  in  RET_WIDTH  method unit return value
- grant_id  out  ID_WIDTH  index of the client currently or last granted
- active  out  1  a call is in flight

Behaviour:
- Reset (reset==0): all outputs 0, FSM to IDLE, round-robin pointer to 0 (client 0 has highest priority), timeout counter cleared.
  - Applies mid-call. m_req drops on the next edge; any stale m_busy is absorbed by the IDLE rule below.
- FSM states: IDLE, ISSUE, RUN, DONE.
- IDLE:
  - Grants only when m_busy==0 and at least one cli_req bit is 1.
  - Winner is the first requesting index found searching from ptr upward, wrapping modulo N_CLIENTS.
  - Next cycle: grant_id=winner, cli_busy[winner]=1, active=1, m_req=1; go to ISSUE.
- ISSUE:
  - m_req held at 1 until m_busy==1 is sampled.
  - On that edge, m_req goes to 0 and the FSM moves to RUN.
- RUN:
  - Waits for m_busy==0.
  - On that edge, m_return is registered into cli_return; go to DONE.
- DONE (exactly 1 cycle):
  - cli_done[grant_id]=1, cli_busy[grant_id]=0, active=0, cli_error=0.
  - ptr becomes grant_id+1, wrapping at N_CLIENTS-1 back to 0. Return to IDLE.
  - cli_return holds its value until the next DONE.
- Latency:
  - Request to m_req is 1 cycle from an idle arbiter.
  - cli_done is 1 cycle after m_busy falls.
  - Minimum back-to-back spacing: the next m_req rises 2 cycles after the previous cli_done.
- Client rule: the client drops cli_req in the cycle cli_done is seen, or no later than the following cycle.
  - A held cli_req is treated as a new request, served after the other pending clients.
  - Deasserting cli_req while granted does not cancel the call.
- Only one cli_busy bit and one cli_done bit is ever 1 at a time.
- Simultaneous requests: the pointer alone decides. No starvation: a waiting client is served within N_CLIENTS-1 other calls.
- grant_id is ID_WIDTH wide; the unused upper values never occur.

Optional Feature:
- Macro: METHOD_CALL_ARBITER_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to ISSUE and increments in ISSUE and RUN.
  - When it reaches TIMEOUT, the call aborts: m_req=0, cli_return=0, cli_error=1 for the DONE cycle. DONE then proceeds as normal, including the pointer update.
  - A method still busy after abort blocks new grants via the m_busy==0 rule in IDLE.
- Not defined:
  - No counter is synthesized. cli_error is tied to 0 and the arbiter waits indefinitely.

Test Plan:
1. reset held 0 for 6 cycles with cli_req=4'b1111 -> all outputs 0; after release, first grant_id=0; m_req rises 1 cycle after release.
2. Single request, client 2. Model raises busy 1 cycle after m_req, holds it 10 cycles, m_return=1 -> cli_busy=4'b0100 throughout the call; cli_done=4'b0100 for exactly 1 cycle, 1 cycle after busy falls; cli_return=1.
3. All four clients request continuously, each re-requesting after done -> grant order 0,1,2,3,0,1; no client served twice before the others; m_return alternating 0/1 shows up on the correct client's cli_return.
4. Reset asserted mid-RUN while the model keeps m_busy=1 for 5 more cycles -> m_req=0 and cli_busy=0 immediately; no grant until m_busy=0; then client 0 is granted.
5. Model holds m_busy low for 3 cycles after m_req -> m_req stays 1 for those 3 cycles; the call completes normally afterwards.
6. With METHOD_CALL_ARBITER_TIMEOUT_EN and TIMEOUT=20, model never releases busy -> cli_done pulse at 20 cycles with cli_error=1 and cli_return=0; next grant is withheld while m_busy=1. Without the macro -> no done after 1000 cycles.

Source files
------------

// File: rtl/method_call_arbiter_if.sv
// Call-handshake bundle between the arbiter, its clients and the shared method unit.
// master: arbiter side (drives client status and m_req).
// slave : environment side (drives client requests and the method unit response).
interface method_call_arbiter_if #(
  parameter int N_CLIENTS = 4,
  parameter int RET_WIDTH = 1,
  parameter int ID_WIDTH  = 2
);
  logic [N_CLIENTS-1:0] cli_req;
  logic [N_CLIENTS-1:0] cli_busy;
  logic [N_CLIENTS-1:0] cli_done;
  logic [RET_WIDTH-1:0] cli_return;
  logic                 cli_error;
  logic                 m_req;
  logic                 m_busy;
  logic [RET_WIDTH-1:0] m_return;
  logic [ID_WIDTH-1:0]  grant_id;
  logic                 active;

  modport master (
    input  cli_req, m_busy, m_return,
    output cli_busy, cli_done, cli_return, cli_error, m_req, grant_id, active
  );

  modport slave (
    output cli_req, m_busy, m_return,
    input  cli_busy, cli_done, cli_return, cli_error, m_req, grant_id, active
  );
endinterface

// File: rtl/method_call_arbiter.sv
// Round-robin arbiter sharing one req/busy/return method unit among N_CLIENTS
// requesters. One call in flight at a time: IDLE -> ISSUE -> RUN -> DONE.
// Optional feature: define METHOD_CALL_ARBITER_TIMEOUT_EN to abort calls that
// exceed TIMEOUT cycles (cli_error flags the aborted call on its done pulse).
module method_call_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int RET_WIDTH = 1,
  parameter int ID_WIDTH  = 2,
  parameter int TIMEOUT   = 100000
) (
  input  logic clk,
  input  logic reset,
  method_call_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_t;

  state_t               state;
  logic [ID_WIDTH-1:0]  ptr;

  logic                 win_vld;
  logic [ID_WIDTH-1:0]  win_id;
  logic [N_CLIENTS-1:0] win_oh;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall (wrap).
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    win_oh  = '0;
    for (int j = N_CLIENTS-1; j >= 0; j--) begin
      if (bus.cli_req[j]) begin
        win_vld   = 1'b1;
        win_id    = ID_WIDTH'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
      end
    end
    for (int j = N_CLIENTS-1; j >= 0; j--) begin
      if (bus.cli_req[j] && (j >= int'(ptr))) begin
        win_id    = ID_WIDTH'(j);
        win_oh    = '0;
        win_oh[j] = 1'b1;
      end
    end
  end

`ifdef METHOD_CALL_ARBITER_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_hit;

  // Counter holds the cycles already spent in ISSUE/RUN; abort on the edge it reaches TIMEOUT.
  assign tmo_hit = (tmo_cnt == 32'(TIMEOUT - 1));
`else
  logic unused_tmo;
  assign unused_tmo    = ^(32'(TIMEOUT));
  assign bus.cli_error = 1'b0;
`endif

  // Call FSM with registered outputs; cli_busy doubles as the granted client's one-hot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.cli_busy   <= '0;
      bus.cli_done   <= '0;
      bus.cli_return <= '0;
      bus.m_req      <= 1'b0;
      bus.grant_id   <= '0;
      bus.active     <= 1'b0;
`ifdef METHOD_CALL_ARBITER_TIMEOUT_EN
      bus.cli_error  <= 1'b0;
      tmo_cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A method still busy (stale call or post-abort) blocks new grants.
          if (!bus.m_busy && win_vld) begin
            bus.grant_id <= win_id;
            bus.cli_busy <= win_oh;
            bus.active   <= 1'b1;
            bus.m_req    <= 1'b1;
            state        <= ISSUE;
`ifdef METHOD_CALL_ARBITER_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end
        end

        ISSUE: begin
`ifdef METHOD_CALL_ARBITER_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 32'd1;
          if (tmo_hit) begin
            bus.m_req      <= 1'b0;
            bus.cli_return <= '0;
            bus.cli_error  <= 1'b1;
            bus.cli_done   <= bus.cli_busy;
            bus.cli_busy   <= '0;
            bus.active     <= 1'b0;
            state          <= DONE;
          end else
`endif
          if (bus.m_busy) begin
            bus.m_req <= 1'b0;
            state     <= RUN;
          end
        end

        RUN: begin
`ifdef METHOD_CALL_ARBITER_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + 32'd1;
          if (tmo_hit) begin
            bus.cli_return <= '0;
            bus.cli_error  <= 1'b1;
            bus.cli_done   <= bus.cli_busy;
            bus.cli_busy   <= '0;
            bus.active     <= 1'b0;
            state          <= DONE;
          end else
`endif
          if (!bus.m_busy) begin
            bus.cli_return <= bus.m_return;
            bus.cli_done   <= bus.cli_busy;
            bus.cli_busy   <= '0;
            bus.active     <= 1'b0;
            state          <= DONE;
          end
        end

        DONE: begin
          // Served client drops to lowest priority for the next round.
          bus.cli_done <= '0;
          ptr          <= (bus.grant_id == ID_WIDTH'(N_CLIENTS - 1)) ? '0 : bus.grant_id + 1'b1;
          state        <= IDLE;
`ifdef METHOD_CALL_ARBITER_TIMEOUT_EN
          bus.cli_error <= 1'b0;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_method_call_arbiter.sv
// Directed bench for method_call_arbiter (N_CLIENTS=4, RET_WIDTH=1, TIMEOUT=20).
// The method unit is modelled inline by driving m_busy/m_return step by step.
module tb_method_call_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  method_call_arbiter_if #(.N_CLIENTS(4), .RET_WIDTH(1), .ID_WIDTH(2)) bus ();

  method_call_arbiter #(
    .N_CLIENTS(4), .RET_WIDTH(1), .ID_WIDTH(2), .TIMEOUT(20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Tick until m_req rises; returns ticks taken, or -1 on timeout (counted as a failure).
  task automatic wait_mreq(input string tag, output int n);
    n = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.m_req === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk({tag, "_mreq_timeout"}, 32'd0, 32'd1);
  endtask

  // Serve the just-granted call: busy for 'hold' cycles, then return 'ret'.
  task automatic serve(input string tag, input int id, input int hold, input logic ret);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'(id));
    chk({tag, "_busy_at_grant"}, 32'(bus.cli_busy), 32'(oh));
    bus.m_busy = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_run_state"}, {bus.m_req, bus.active, bus.cli_busy, bus.cli_done},
          {1'b0, 1'b1, oh, 4'b0000});
    end
    bus.m_busy   = 1'b0;
    bus.m_return = ret;
    tick();
    chk({tag, "_done"}, {bus.cli_done, bus.cli_busy, bus.active, bus.cli_return, bus.cli_error},
        {oh, 4'b0000, 1'b0, ret, 1'b0});
    bus.m_return = ~ret;
    tick();
    chk({tag, "_done_pulse_end"}, {bus.cli_done, bus.cli_return}, {4'b0000, ret});
  endtask

  initial begin
    int n;
    logic seen_done;
    bus.cli_req  = 4'b1111;
    bus.m_busy   = 1'b0;
    bus.m_return = 1'b0;

    // 1: reset held with all requesting
    repeat (6) tick();
    chk("reset_outputs", {bus.cli_busy, bus.cli_done, bus.cli_return, bus.cli_error,
                          bus.m_req, bus.grant_id, bus.active}, 32'd0);
    reset = 1'b1;
    tick();
    chk("first_grant", {bus.m_req, bus.grant_id, bus.cli_busy, bus.active},
        {1'b1, 2'd0, 4'b0001, 1'b1});
    bus.cli_req = 4'b0000;
    serve("t1", 0, 1, 1'b0);

    // 2: single request, client 2, busy 10 cycles
    bus.cli_req = 4'b0100;
    wait_mreq("t2", n);
    chk("t2_req_latency", 32'(n), 32'd1);
    bus.cli_req = 4'b0000;
    serve("t2", 2, 10, 1'b1);

    // 3: all clients requesting continuously, fresh pointer
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.cli_req = 4'b1111;
    wait_mreq("t3_0", n);
    serve("t3_0", 0, 2, 1'b0);
    wait_mreq("t3_1", n);
    chk("t3_b2b_spacing", 32'(n), 32'd1);
    serve("t3_1", 1, 3, 1'b1);
    wait_mreq("t3_2", n);
    serve("t3_2", 2, 1, 1'b0);
    wait_mreq("t3_3", n);
    serve("t3_3", 3, 2, 1'b1);
    wait_mreq("t3_4", n);
    serve("t3_4", 0, 1, 1'b0);
    wait_mreq("t3_5", n);
    serve("t3_5", 1, 2, 1'b1);

    // 4: reset mid-RUN while method stays busy
    wait_mreq("t4", n);
    chk("t4_grant_id", 32'(bus.grant_id), 32'd2);
    bus.m_busy = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("t4_reset_mid_run", {bus.m_req, bus.cli_busy, bus.active}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_no_grant_while_busy", {bus.m_req, bus.active, bus.cli_busy}, 32'd0);
    end
    bus.m_busy = 1'b0;
    tick();
    chk("t4_regrant", {bus.m_req, bus.grant_id}, {1'b1, 2'd0});
    serve("t4", 0, 2, 1'b1);

    // 5: method slow to accept; m_req must hold
    wait_mreq("t5", n);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_mreq_held", {bus.m_req, bus.active}, 2'b11);
    end
    serve("t5", 1, 3, 1'b1);
    bus.cli_req = 4'b0000;
    tick();

    // 6: method never releases busy
    bus.cli_req = 4'b1000;
    wait_mreq("t6", n);
    chk("t6_grant_id", 32'(bus.grant_id), 32'd3);
    bus.m_busy = 1'b1;
`ifdef METHOD_CALL_ARBITER_TIMEOUT_EN
    seen_done = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      seen_done = seen_done | (|bus.cli_done);
    end
    chk("t6_no_early_done", 32'(seen_done), 32'd0);
    tick();
    chk("t6_abort", {bus.cli_done, bus.cli_error, bus.cli_return, bus.m_req, bus.active},
        {4'b1000, 1'b1, 1'b0, 1'b0, 1'b0});
    tick();
    chk("t6_abort_end", {bus.cli_done, bus.cli_error}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_withheld", {bus.m_req, bus.active}, 32'd0);
    end
    bus.m_busy = 1'b0;
    tick();
    chk("t6_regrant", {bus.m_req, bus.grant_id}, {1'b1, 2'd3});
`else
    seen_done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      seen_done = seen_done | (|bus.cli_done) | bus.cli_error;
    end
    chk("t6_no_done", 32'(seen_done), 32'd0);
    chk("t6_still_active", {bus.active, bus.cli_busy}, {1'b1, 4'b1000});
`endif
    bus.cli_req = 4'b0000;
    bus.m_busy  = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
